axis_demux_route: RTL and testbench
===================================

# axis_demux_route

Upstream route-decision stage for `axis_demux`. Inspects `tdest` on the first beat of each AXI-Stream frame and matches it against a per-output match/mask table. It then forwards the frame through a full-throughput skid buffer, with `m_select`/`m_drop` sideband held constant for the whole frame. Its outputs connect directly to the demux `s_axis_*`, `select` and `drop` inputs, so the demux always samples a settled route at frame start.

## Interface
- `M_COUNT`, 4: number of demux outputs / route table entries
- `DATA_WIDTH`, 64: tdata width
- `KEEP_ENABLE`, (DATA_WIDTH>8): carry tkeep
- `KEEP_WIDTH`, DATA_WIDTH/8: tkeep width
- `ID_ENABLE`, 1: carry tid
- `ID_WIDTH`, 8: tid width
- `DEST_WIDTH`, 8: tdest width (tdest always carried)
- `USER_ENABLE`, 1: carry tuser
- `USER_WIDTH`, 1: tuser width

Ports:
- `clk`  in  1  clock; one clock domain only
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `s_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  in (tready out)  per parameters  input stream
- `m_axis_tdata/tkeep/tvalid/tready/tlast/tid/tdest/tuser`  out (tready in)  per parameters  output stream to demux
- `m_select`  out  $clog2(M_COUNT)  chosen output, valid with `m_axis_tvalid`
- `m_drop`  out  1  frame matched no entry
- `route_match`  in  M_COUNT*DEST_WIDTH  per-entry tdest match value
- `route_mask`  in  M_COUNT*DEST_WIDTH  per-entry compare mask (1 = bit compared)
- `route_enable`  in  M_COUNT  per-entry enable
- `stat_drop_count`  out  16  saturating count of dropped frames

## Operation
- Entry i hits when `route_enable[i]` and `((tdest ^ match_i) & mask_i) == 0`. A mask of 0 matches any tdest.
- Priority: the lowest-index hitting entry wins and sets select = i, drop = 0.
- No hit: select = 0, drop = 1.
- Decision is evaluated only on the first beat of a frame, i.e. a beat accepted while `in_frame` = 0.
- The decision is latched in `route_sel`/`route_drop` and applied to every beat of the frame. `route_*` changes mid-frame take effect at the next frame.
- FSM states:
  - IDLE → FRAME on accepting a non-last beat.
  - FRAME → IDLE on accepting a beat with tlast.
  - IDLE stays IDLE on a single-beat frame (tlast on first beat).
- Each skid-buffer entry stores the beat plus its select/drop. `m_select`/`m_drop` therefore change only at frame boundaries as seen on the output side.
- Dropped frames are still forwarded with `m_drop` = 1; the demux discards them.
- `stat_drop_count` increments by 1 on acceptance of the first beat of a no-hit frame. It saturates at 0xFFFF and never wraps.
- Disabled fields (keep/id/user) output constant 1s for tkeep and 0 for the others.

## Timing
- Latency: 1 cycle from input acceptance to `m_axis_tvalid`.
- Throughput: 1 beat/cycle with `m_axis_tready` held high.
- `s_axis_tready` is registered: high when the temp register is empty. Output register plus temp register form the 2-entry skid.
- Output stall: `m_axis_*`, `m_select` and `m_drop` stay stable while `tvalid` && !`tready`.
- A beat in flight when `m_axis_tready` drops lands in the temp register, and `s_axis_tready` deasserts the next cycle. No beat is lost or duplicated.
- Reset values (`rst_n` low):
  - `m_axis_tvalid` = 0, `s_axis_tready` = 0
  - `m_select` = 0, `m_drop` = 0
  - `stat_drop_count` = 0, FSM = IDLE
  - data registers = 0
  - `s_axis_tready` rises on the first clock edge after release.
- Reset mid-frame: buffered beats are discarded. The next accepted beat is treated as a frame start and gets a fresh lookup.

## Structure
- Shared package: route-entry width constant (`DEST_WIDTH`) and a `route_lookup` function (match/mask/priority → {hit, index}). The same lookup is reused by later mux/arb routing stages.
- One sub-module is natural: `axis_skid_reg`, the 2-entry output/temp register carrying a generic payload vector. The top level concatenates beat fields with select/drop into that payload.
- Top level holds only the FSM, lookup, route latch and drop counter.

## Test plan
- Table {0:0x10/0xF0, 1:0x20/0xF0, others disabled}; 3-beat frame tdest=0x2A → all beats `m_select`=1, `m_drop`=0, data unchanged, latency 1.
- tdest=0x15 with entries 0 and 1 both mask 0x00 → `m_select`=0 (priority). Entry 0 disabled → `m_select`=1.
- tdest=0x77, no hit → frame forwarded with `m_drop`=1. Then 0x10000 such frames → `stat_drop_count` stops at 0xFFFF.
- Change `route_match[0]` mid-frame → remainder of frame keeps the old select; next frame uses the new one.
- Random `m_axis_tready` (50%) over 200 mixed frames, including 1-beat frames → output beat sequence equals input sequence, zero loss, select constant per frame.
- Assert `rst_n` low on beat 2 of a 4-beat frame → `m_axis_tvalid`=0 at once. After release, a new frame with tdest=0x20 routes to select=1.

Source files
------------

// File: rtl/axis_demux_route_pkg.sv
// Shared routing definitions: route-entry geometry and the match/mask/priority lookup
// reused by the demux, mux and arbiter routing stages.
package axis_demux_route_pkg;

  localparam int unsigned ROUTE_DEST_WIDTH = 8;
  localparam int unsigned ROUTE_MAX_COUNT  = 16;
  localparam int unsigned ROUTE_IDX_WIDTH  = $clog2(ROUTE_MAX_COUNT);

  typedef struct packed {
    logic                       hit;
    logic [ROUTE_IDX_WIDTH-1:0] index;
  } route_result_t;

  // Lowest-index enabled entry whose masked bits equal tdest wins; no hit returns index 0
  function automatic route_result_t route_lookup(
    input logic [ROUTE_DEST_WIDTH-1:0]                 dest,
    input logic [ROUTE_MAX_COUNT*ROUTE_DEST_WIDTH-1:0] match,
    input logic [ROUTE_MAX_COUNT*ROUTE_DEST_WIDTH-1:0] mask,
    input logic [ROUTE_MAX_COUNT-1:0]                  enable
  );
    route_result_t res;
    res = '0;
    for (int i = int'(ROUTE_MAX_COUNT) - 1; i >= 0; i--) begin
      if (enable[i] &&
          (((dest ^ match[i*ROUTE_DEST_WIDTH +: ROUTE_DEST_WIDTH]) &
            mask[i*ROUTE_DEST_WIDTH +: ROUTE_DEST_WIDTH]) == '0)) begin
        res.hit   = 1'b1;
        res.index = ROUTE_IDX_WIDTH'(i);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/axis_skid_reg.sv
// Two-entry full-throughput skid register (output + temp) carrying an opaque payload.
// s_ready is registered and is high exactly when the temp entry is empty.
module axis_skid_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_payload,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_payload,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] temp_payload;
  logic             temp_valid;
  logic             out_free;
  logic             accept;
  logic             temp_valid_next;

  assign out_free        = !m_valid || m_ready;
  assign accept          = s_valid && s_ready;
  assign temp_valid_next = temp_valid ? !out_free : (accept && !out_free);

  // A beat arriving while the output is stalled parks in temp
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_payload    <= '0;
      m_valid      <= 1'b0;
      temp_payload <= '0;
      temp_valid   <= 1'b0;
      s_ready      <= 1'b0;
    end else begin
      s_ready    <= !temp_valid_next;
      temp_valid <= temp_valid_next;
      if (out_free) begin
        if (temp_valid) begin
          m_payload <= temp_payload;
          m_valid   <= 1'b1;
        end else begin
          m_valid <= accept;
          if (accept) m_payload <= s_payload;
        end
      end else if (accept) begin
        temp_payload <= s_payload;
      end
    end
  end

endmodule

// File: rtl/axis_demux_route.sv
// Route-decision stage ahead of axis_demux: looks up tdest on the first beat of each
// frame and forwards the frame with a select/drop sideband held for the whole frame.
module axis_demux_route
  import axis_demux_route_pkg::*;
#(
  parameter int unsigned M_COUNT     = 4,
  parameter int unsigned DATA_WIDTH  = 64,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8,
  parameter bit          ID_ENABLE   = 1'b1,
  parameter int unsigned ID_WIDTH    = 8,
  parameter int unsigned DEST_WIDTH  = 8,
  parameter bit          USER_ENABLE = 1'b1,
  parameter int unsigned USER_WIDTH  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [ID_WIDTH-1:0]           s_axis_tid,
  input  logic [DEST_WIDTH-1:0]         s_axis_tdest,
  input  logic [USER_WIDTH-1:0]         s_axis_tuser,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic [DEST_WIDTH-1:0]         m_axis_tdest,
  output logic [USER_WIDTH-1:0]         m_axis_tuser,
  output logic [$clog2(M_COUNT)-1:0]    m_select,
  output logic                          m_drop,
  input  logic [M_COUNT*DEST_WIDTH-1:0] route_match,
  input  logic [M_COUNT*DEST_WIDTH-1:0] route_mask,
  input  logic [M_COUNT-1:0]            route_enable,
  output logic [15:0]                   stat_drop_count
);

  localparam int unsigned SEL_WIDTH     = $clog2(M_COUNT);
  localparam int unsigned PAYLOAD_WIDTH = DATA_WIDTH + KEEP_WIDTH + 1 + ID_WIDTH +
                                          DEST_WIDTH + USER_WIDTH + SEL_WIDTH + 1;

  typedef enum logic {ST_IDLE, ST_FRAME} state_t;

  state_t state_q, state_d;

  logic beat_accept;
  logic first_beat;

  assign beat_accept = s_axis_tvalid && s_axis_tready;
  assign first_beat  = beat_accept && (state_q == ST_IDLE);

  // Widen the table to the shared lookup geometry and decode the winning index
  logic [ROUTE_MAX_COUNT*ROUTE_DEST_WIDTH-1:0] match_ext;
  logic [ROUTE_MAX_COUNT*ROUTE_DEST_WIDTH-1:0] mask_ext;
  logic [ROUTE_MAX_COUNT-1:0]                  enable_ext;
  route_result_t                               lookup;
  logic [SEL_WIDTH-1:0]                        lookup_sel;

  always_comb begin
    match_ext  = '0;
    mask_ext   = '0;
    enable_ext = '0;
    for (int i = 0; i < int'(M_COUNT); i++) begin
      match_ext[i*ROUTE_DEST_WIDTH +: ROUTE_DEST_WIDTH] =
        ROUTE_DEST_WIDTH'(route_match[i*DEST_WIDTH +: DEST_WIDTH]);
      mask_ext[i*ROUTE_DEST_WIDTH +: ROUTE_DEST_WIDTH] =
        ROUTE_DEST_WIDTH'(route_mask[i*DEST_WIDTH +: DEST_WIDTH]);
      enable_ext[i] = route_enable[i];
    end
    lookup     = route_lookup(ROUTE_DEST_WIDTH'(s_axis_tdest), match_ext, mask_ext, enable_ext);
    lookup_sel = '0;
    for (int i = 0; i < int'(M_COUNT); i++) begin
      if (lookup.index == ROUTE_IDX_WIDTH'(i)) lookup_sel = SEL_WIDTH'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (beat_accept && !s_axis_tlast) state_d = ST_FRAME;
      ST_FRAME: if (beat_accept && s_axis_tlast)  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Route latched at frame start; the first beat uses the live lookup directly
  logic [SEL_WIDTH-1:0] route_sel;
  logic                 route_drop;
  logic [SEL_WIDTH-1:0] beat_sel;
  logic                 beat_drop;

  assign beat_sel  = first_beat ? lookup_sel  : route_sel;
  assign beat_drop = first_beat ? !lookup.hit : route_drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      route_sel       <= '0;
      route_drop      <= 1'b0;
      stat_drop_count <= '0;
    end else if (first_beat) begin
      route_sel  <= lookup_sel;
      route_drop <= !lookup.hit;
      if (!lookup.hit && (stat_drop_count != 16'hFFFF)) stat_drop_count <= stat_drop_count + 16'd1;
    end
  end

  logic [PAYLOAD_WIDTH-1:0] s_payload;
  logic [PAYLOAD_WIDTH-1:0] m_payload;
  logic [KEEP_WIDTH-1:0]    out_keep;
  logic [ID_WIDTH-1:0]      out_id;
  logic [USER_WIDTH-1:0]    out_user;

  assign s_payload = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid,
                      s_axis_tdest, s_axis_tuser, beat_sel, beat_drop};

  axis_skid_reg #(
    .WIDTH(PAYLOAD_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_payload(s_payload),
    .s_valid  (s_axis_tvalid),
    .s_ready  (s_axis_tready),
    .m_payload(m_payload),
    .m_valid  (m_axis_tvalid),
    .m_ready  (m_axis_tready)
  );

  assign {m_axis_tdata, out_keep, m_axis_tlast, out_id,
          m_axis_tdest, out_user, m_select, m_drop} = m_payload;

  assign m_axis_tkeep = KEEP_ENABLE ? out_keep : '1;
  assign m_axis_tid   = ID_ENABLE   ? out_id   : '0;
  assign m_axis_tuser = USER_ENABLE ? out_user : '0;

endmodule

// File: tb/tb_axis_demux_route.sv
// Self-checking bench for axis_demux_route: directed route cases plus randomized
// frames with random backpressure, scored against a frame-level routing model.
module tb_axis_demux_route;

  logic        clk;
  logic        rst_n;
  logic [63:0] s_axis_tdata;
  logic [7:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [7:0]  s_axis_tid;
  logic [7:0]  s_axis_tdest;
  logic [0:0]  s_axis_tuser;
  logic [63:0] m_axis_tdata;
  logic [7:0]  m_axis_tkeep;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tid;
  logic [7:0]  m_axis_tdest;
  logic [0:0]  m_axis_tuser;
  logic [1:0]  m_select;
  logic        m_drop;
  logic [31:0] route_match;
  logic [31:0] route_mask;
  logic [3:0]  route_enable;
  logic [15:0] stat_drop_count;

  logic [7:0] tb_match [4];
  logic [7:0] tb_mask  [4];
  logic [3:0] tb_en;

  always_comb begin
    route_match = '0;
    route_mask  = '0;
    for (int i = 0; i < 4; i++) begin
      route_match[i*8 +: 8] = tb_match[i];
      route_mask[i*8 +: 8]  = tb_mask[i];
    end
    route_enable = tb_en;
  end

  axis_demux_route dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tkeep   (s_axis_tkeep),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .s_axis_tlast   (s_axis_tlast),
    .s_axis_tid     (s_axis_tid),
    .s_axis_tdest   (s_axis_tdest),
    .s_axis_tuser   (s_axis_tuser),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tkeep   (m_axis_tkeep),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tid     (m_axis_tid),
    .m_axis_tdest   (m_axis_tdest),
    .m_axis_tuser   (m_axis_tuser),
    .m_select       (m_select),
    .m_drop         (m_drop),
    .route_match    (route_match),
    .route_mask     (route_mask),
    .route_enable   (route_enable),
    .stat_drop_count(stat_drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
    logic [7:0]  id;
    logic [7:0]  dest;
    logic        user;
    logic [1:0]  sel;
    logic        drop;
  } beat_t;

  int    n_checks = 0;
  int    n_errors = 0;
  beat_t exp_q[$];
  beat_t mon_exp;
  beat_t prev_out;
  bit    prev_stall = 0;
  bit    mdl_in_frame = 0;
  logic [1:0] mdl_sel = '0;
  bit    mdl_drop = 0;
  int    mdl_drops = 0;
  bit    rand_ready = 0;
  bit    gaps = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference routing rule: first enabled entry whose masked bits agree with tdest
  task automatic model_route(input logic [7:0] dest, output logic [1:0] sel, output bit drop);
    drop = 1;
    sel  = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (drop && tb_en[i] && (((dest ^ tb_match[i]) & tb_mask[i]) == 8'h00)) begin
        sel  = 2'(i);
        drop = 0;
      end
    end
  endtask

  function automatic beat_t out_beat();
    return '{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tid,
             m_axis_tdest, m_axis_tuser[0], m_select, m_drop};
  endfunction

  // Monitor: inputs only change at posedge+1, so negedge values are what the next edge samples
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_tvalid", 128'(m_axis_tvalid), 128'(0));
      exp_q.delete();
      mdl_in_frame = 0;
      mdl_drops    = 0;
      prev_stall   = 0;
    end else begin
      if (prev_stall) check("stall_hold", 128'(out_beat()), 128'(prev_out));
      check("drop_count", 128'(stat_drop_count), 128'(mdl_drops));
      if (s_axis_tvalid && s_axis_tready) begin
        if (!mdl_in_frame) begin
          model_route(s_axis_tdest, mdl_sel, mdl_drop);
          if (mdl_drop && mdl_drops < 65535) mdl_drops++;
        end
        mdl_in_frame = !s_axis_tlast;
        mon_exp = '{s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tid,
                    s_axis_tdest, s_axis_tuser[0], mdl_sel, mdl_drop};
        exp_q.push_back(mon_exp);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("sb_avail", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) check("beat", 128'(out_beat()), 128'(exp_q.pop_front()));
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_out   = out_beat();
    end
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Drive one beat from posedge+1 and return at posedge+1 of the accepting edge
  task automatic send_beat(input logic [63:0] data, input logic last, input logic [7:0] dest);
    bit ok;
    int guard;
    if (gaps) begin
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    s_axis_tdata  = data;
    s_axis_tkeep  = 8'($urandom);
    s_axis_tid    = 8'($urandom);
    s_axis_tuser  = 1'($urandom);
    s_axis_tdest  = dest;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    ok    = 0;
    guard = 0;
    while (!ok && guard < 1000) begin
      @(negedge clk);
      ok = s_axis_tready;
      @(posedge clk);
      #1;
      guard++;
    end
    check("send_accept", 128'(ok), 128'(1));
    s_axis_tvalid = 1'b0;
  endtask

  task automatic set_entry(input int i, input logic [7:0] match, input logic [7:0] mask);
    tb_match[i] = match;
    tb_mask[i]  = mask;
  endtask

  logic [63:0] d;
  int          len;
  logic [7:0]  dest;

  initial begin
    rst_n = 1'b0;
    s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tid = '0; s_axis_tdest = '0; s_axis_tuser = '0; m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) set_entry(i, 8'h00, 8'h00);
    tb_en = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sready", 128'(s_axis_tready), 128'(0));
    check("rst_select", 128'(m_select), 128'(0));
    check("rst_drop", 128'(m_drop), 128'(0));
    check("rst_count", 128'(stat_drop_count), 128'(0));
    check("rst_tdata", 128'(m_axis_tdata), 128'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("sready_rise", 128'(s_axis_tready), 128'(1));

    // Basic routing: 0x2A hits entry 1 only
    set_entry(0, 8'h10, 8'hF0);
    set_entry(1, 8'h20, 8'hF0);
    tb_en = 4'b0011;
    for (int b = 0; b < 3; b++) begin
      d = {$urandom, $urandom};
      send_beat(d, b == 2, 8'h2A);
      check("t1_valid", 128'(m_axis_tvalid), 128'(1));
      check("t1_data", 128'(m_axis_tdata), 128'(d));
      check("t1_sel", 128'(m_select), 128'(1));
      check("t1_drop", 128'(m_drop), 128'(0));
    end

    // Priority between two catch-all entries
    set_entry(0, 8'h00, 8'h00);
    set_entry(1, 8'h00, 8'h00);
    send_beat({$urandom, $urandom}, 1'b1, 8'h15);
    check("prio_sel0", 128'(m_select), 128'(0));
    tb_en = 4'b0010;
    send_beat({$urandom, $urandom}, 1'b1, 8'h15);
    check("prio_sel1", 128'(m_select), 128'(1));
    check("prio_drop", 128'(m_drop), 128'(0));

    // No hit: forwarded with drop set and counted
    set_entry(0, 8'h10, 8'hF0);
    set_entry(1, 8'h20, 8'hF0);
    tb_en = 4'b0011;
    send_beat({$urandom, $urandom}, 1'b1, 8'h77);
    check("nohit_drop", 128'(m_drop), 128'(1));
    check("nohit_sel", 128'(m_select), 128'(0));
    check("nohit_count", 128'(stat_drop_count), 128'(1));

    // Table change mid-frame applies only from the next frame
    send_beat({$urandom, $urandom}, 1'b0, 8'h12);
    check("mid_sel_b0", 128'(m_select), 128'(0));
    set_entry(0, 8'h30, 8'hF0);
    for (int b = 1; b < 3; b++) begin
      send_beat({$urandom, $urandom}, b == 2, 8'h12);
      check("mid_sel_keep", 128'(m_select), 128'(0));
      check("mid_drop_keep", 128'(m_drop), 128'(0));
    end
    send_beat({$urandom, $urandom}, 1'b1, 8'h12);
    check("mid_next_drop", 128'(m_drop), 128'(1));
    check("mid_next_count", 128'(stat_drop_count), 128'(2));

    // Randomized frames with random backpressure and source gaps
    rand_ready = 1;
    gaps       = 1;
    for (int f = 0; f < 200; f++) begin
      if (f % 25 == 0) begin
        for (int i = 0; i < 4; i++) begin
          case ($urandom_range(0, 3))
            0: set_entry(i, {2'b00, 2'($urandom), 4'($urandom)}, 8'hF0);
            1: set_entry(i, 8'($urandom), 8'h00);
            2: set_entry(i, {2'b00, 6'($urandom)}, 8'hFF);
            default: set_entry(i, 8'($urandom), 8'($urandom));
          endcase
        end
        tb_en = 4'($urandom);
      end
      len  = $urandom_range(1, 4);
      dest = ($urandom_range(0, 3) == 0) ? 8'($urandom) : {2'b00, 2'($urandom), 4'($urandom)};
      for (int b = 0; b < len; b++) send_beat({$urandom, $urandom}, b == len - 1, dest);
    end
    rand_ready = 0;
    gaps       = 0;
    repeat (6) @(posedge clk);
    #1;
    check("drain_empty", 128'(exp_q.size()), 128'(0));

    // Reset on beat 2 of a 4-beat frame discards it and restarts lookup
    set_entry(0, 8'h10, 8'hF0);
    set_entry(1, 8'h20, 8'hF0);
    tb_en = 4'b0011;
    send_beat({$urandom, $urandom}, 1'b0, 8'h10);
    check("rstmid_sel0", 128'(m_select), 128'(0));
    send_beat({$urandom, $urandom}, 1'b0, 8'h10);
    rst_n = 1'b0;
    #1;
    check("rstmid_tvalid", 128'(m_axis_tvalid), 128'(0));
    check("rstmid_sready", 128'(s_axis_tready), 128'(0));
    check("rstmid_count", 128'(stat_drop_count), 128'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rstrel_sready", 128'(s_axis_tready), 128'(0));
    @(posedge clk);
    #1;
    check("rstrel_rise", 128'(s_axis_tready), 128'(1));
    d = {$urandom, $urandom};
    send_beat(d, 1'b1, 8'h20);
    check("rstrel_sel", 128'(m_select), 128'(1));
    check("rstrel_drop", 128'(m_drop), 128'(0));
    check("rstrel_data", 128'(m_axis_tdata), 128'(d));

    // Drop counter saturation after 0x10000 dropped frames
    tb_en = 4'b0000;
    for (int f = 0; f < 65535; f++) send_beat({$urandom, $urandom}, 1'b1, 8'h77);
    check("sat_reach", 128'(stat_drop_count), 128'(16'hFFFF));
    send_beat({$urandom, $urandom}, 1'b1, 8'h77);
    check("sat_hold", 128'(stat_drop_count), 128'(16'hFFFF));
    check("sat_drop", 128'(m_drop), 128'(1));
    repeat (3) @(posedge clk);
    #1;
    check("final_empty", 128'(exp_q.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
